// File: rtl/mssd_tx_if.sv
// mssd_tx_if: host-side frame request, nibble handshake and serial line of the MSSD transmitter
interface mssd_tx_if #(parameter int LEN_W = 3);
    logic             send;
    logic [1:0]       pn_in;
    logic [LEN_W-1:0] len_in;
    logic             nib_valid;
    logic [3:0]       nib_data;
    logic             nib_ready;
    logic             busy;
    logic             done;
    logic             underrun;
    logic             SerOut;
    modport master (output send, pn_in, len_in, nib_valid, nib_data,
                    input nib_ready, busy, done, underrun, SerOut);
    modport slave  (input send, pn_in, len_in, nib_valid, nib_data,
                    output nib_ready, busy, done, underrun, SerOut);
endinterface

// File: rtl/mssd_tx.sv
// mssd_tx: MSSD serial frame transmitter, MSB-first START/PN/LEN/nibbles/STOP.
// Define MSSD_TX_PARITY_EN to append an even-parity bit after every nibble.
module mssd_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int LEN_W        = 3
) (
    input logic      clk,
    input logic      rst,
    mssd_tx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(LEN_W > 4 ? LEN_W : 4) + 1;
    typedef enum logic [2:0] {IDLE, START, PN, LEN, DATA,
`ifdef MSSD_TX_PARITY_EN
        PAR,
`endif
        STOP} state_t;
    // state whose last cycle is the load slot for the next nibble
`ifdef MSSD_TX_PARITY_EN
    localparam state_t NIB_END = PAR;
`else
    localparam state_t NIB_END = DATA;
`endif
    state_t           r_state, w_next;
    logic [CW-1:0]    r_clk;
    logic [BW-1:0]    r_bit, w_fw;
    logic [1:0]       r_pn;
    logic [LEN_W-1:0] r_len, r_nib;
    logic [3:0]       r_sh;
    logic             r_done, w_tick, w_last, w_slot;
`ifdef MSSD_TX_PARITY_EN
    logic             r_par;
`endif
    always_comb begin
        w_tick = r_clk == CW'(CLKS_PER_BIT - 1);
        w_fw   = r_state == PN ? BW'(2) : r_state == LEN ? BW'(LEN_W) : r_state == DATA ? BW'(4) : BW'(1);
        w_last = w_tick && r_bit == w_fw - BW'(1);
        w_slot = w_last && r_nib != '0 && (r_state == LEN || r_state == NIB_END);
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.send ? START : IDLE;
            START:   w_next = w_last ? PN : START;
            PN:      w_next = w_last ? LEN : PN;
`ifdef MSSD_TX_PARITY_EN
            DATA:    w_next = w_last ? PAR : DATA;
`endif
            STOP:    w_next = w_last ? IDLE : STOP;
            default: ;
        endcase
        if (w_last && (r_state == LEN || r_state == NIB_END))
            w_next = r_nib == '0 ? STOP : bus.nib_valid ? DATA : IDLE;
    end
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_done;
    assign bus.nib_ready = w_slot && bus.nib_valid;
    assign bus.underrun  = w_slot && !bus.nib_valid;
    assign bus.SerOut    = r_state == START ? 1'b0 : r_state == PN ? r_pn[1] :
                           r_state == LEN ? r_len[LEN_W-1] : r_state == DATA ? r_sh[3] :
`ifdef MSSD_TX_PARITY_EN
                           r_state == PAR ? r_par :
`endif
                           1'b1;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk  <= '0;
            r_bit  <= '0;
            r_pn   <= '0;
            r_len  <= '0;
            r_nib  <= '0;
            r_sh   <= '0;
            r_done <= 1'b0;
`ifdef MSSD_TX_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else begin
            r_done <= r_state == STOP && w_last;
            r_clk  <= (r_state == IDLE || w_tick) ? '0 : r_clk + CW'(1);
            r_bit  <= (r_state == IDLE || w_last) ? '0 : w_tick ? r_bit + BW'(1) : r_bit;
            if (r_state == IDLE && bus.send) begin
                r_pn  <= bus.pn_in;
                r_len <= bus.len_in;
                r_nib <= bus.len_in;
            end
            if (r_state == PN && w_tick) r_pn <= r_pn << 1;
            if (r_state == LEN && w_tick) r_len <= r_len << 1;
            if (r_state == DATA && w_tick) r_sh <= r_sh << 1;
            if (bus.nib_ready) begin
                r_sh  <= bus.nib_data;
                r_nib <= r_nib - LEN_W'(1);
`ifdef MSSD_TX_PARITY_EN
                r_par <= ^bus.nib_data;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mssd_tx.sv
// tb_mssd_tx: randomized frames checked cycle by cycle against a bit-list model of the MSSD frame
module tb_mssd_tx;
    localparam int CPB = 3;
    localparam int LW  = 3;
`ifdef MSSD_TX_PARITY_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    mssd_tx_if #(.LEN_W(LW)) bus();
    mssd_tx #(.CLKS_PER_BIT(CPB), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic idle(input int n);
        bus.send = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_ser", bus.SerOut, 1);
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_ready", bus.nib_ready, 0);
        end
    endtask
    // nsent < len drops nib_valid before nibble nsent; hold keeps send high and scrambles pn/len while busy
    task automatic run_frame(input int pn, input int len, input int nsent, input bit hold,
                             input bit use_fixed, input logic [7:0] fixed);
        logic [3:0] nibs[8];
        bit         q[$];
        int         k = 0;
        int         rdy = 0;
        int         ncyc;
        bit         full = nsent == len;
        bit         r;
        for (int i = 0; i < 8; i++) nibs[i] = 4'($urandom);
        if (use_fixed) begin
            nibs[0] = fixed[7:4];
            nibs[1] = fixed[3:0];
        end
        q.push_back(1'b0);
        for (int i = 1; i >= 0; i--) q.push_back(bit'((pn >> i) & 1));
        for (int i = LW - 1; i >= 0; i--) q.push_back(bit'((len >> i) & 1));
        for (int n = 0; n < nsent; n++) begin
            for (int i = 3; i >= 0; i--) q.push_back(nibs[n][i]);
            if (PE) q.push_back(^nibs[n]);
        end
        if (full) q.push_back(1'b1);
        ncyc = q.size() * CPB;
        bus.send      = 1'b1;
        bus.pn_in     = 2'(pn);
        bus.len_in    = LW'(len);
        bus.nib_valid = nsent > 0;
        bus.nib_data  = nibs[0];
        @(posedge clk);
        #1;
        if (!hold) bus.send = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk("ser", bus.SerOut, q[c / CPB]);
            chk("busy", bus.busy, 1);
            chk("done_early", bus.done, 0);
            chk("underrun", bus.underrun, !full && c == ncyc - 1);
            r = bus.nib_ready;
            if (r) rdy++;
            @(posedge clk);
            #1;
            if (hold) begin
                bus.pn_in  = 2'($urandom);
                bus.len_in = LW'($urandom);
            end
            if (r) begin
                k++;
                bus.nib_data  = nibs[k];
                bus.nib_valid = k < nsent;
            end
        end
        @(negedge clk);
        chk("end_busy", bus.busy, 0);
        chk("end_ser", bus.SerOut, 1);
        chk("end_done", bus.done, full);
        chk("end_underrun", bus.underrun, 0);
        chk("ready_count", rdy, nsent);
    endtask
    initial begin
        int len, ns;
        bus.send = 1'b0; bus.pn_in = '0; bus.len_in = '0; bus.nib_valid = 1'b0; bus.nib_data = '0;
        #1;
        chk("rst_ser", bus.SerOut, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_underrun", bus.underrun, 0);
        chk("rst_ready", bus.nib_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        run_frame(2, 2, 2, 1'b0, 1'b1, 8'hA7);
        idle(1);
        run_frame(3, 0, 0, 1'b0, 1'b0, 8'h00);
        idle(1);
        run_frame(1, 3, 1, 1'b0, 1'b0, 8'h00);
        idle(2);
        bus.send = 1'b1; bus.pn_in = 2'd1; bus.len_in = LW'(5); bus.nib_valid = 1'b1; bus.nib_data = 4'h9;
        @(posedge clk);
        #1 bus.send = 1'b0;
        repeat (24) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_ser", bus.SerOut, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.nib_ready, 0);
        chk("midrst_underrun", bus.underrun, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        run_frame(2, 4, 4, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(0, 7);
            run_frame(int'($urandom_range(0, 3)), len, len, 1'b1, 1'b0, 8'h00);
        end
        idle(2);
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(0, 7);
            ns  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : len;
            run_frame(int'($urandom_range(0, 3)), len, ns, 1'b0, 1'b0, 8'h00);
            idle(int'($urandom_range(0, 2)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
